// File: rtl/vga_grid_renderer.sv
// 640x480 VGA timing generator that paints a GRID_ROWS x GRID_COLS bitmap of coloured cells.
// Rows are written only during vertical blanking; the pixel path is a two-stage pix_ce pipeline.
module vga_grid_renderer #(
    parameter int          GRID_COLS = 8,
    parameter int          GRID_ROWS = 8,
    parameter int          CELL_W    = 80,
    parameter int          CELL_H    = 60,
    parameter int          FLIP_ROWS = 1,
    parameter logic [7:0]  BG_COLOR  = 8'h00
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 pix_ce,
    input  logic                 clr,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [3:0]           wr_row,
    input  logic [GRID_COLS-1:0] wr_data,
    input  logic [7:0]           wr_color,
    output logic                 wr_err,
    output logic                 vga_h_sync,
    output logic                 vga_v_sync,
    output logic [2:0]           vga_r,
    output logic [2:0]           vga_g,
    output logic [1:0]           vga_b,
    output logic                 frame_start
);

    localparam logic [9:0] H_LAST   = 10'd799;
    localparam logic [9:0] V_LAST   = 10'd524;
    localparam logic [9:0] H_VIS    = 10'd640;
    localparam logic [9:0] V_VIS    = 10'd480;
    localparam logic [9:0] HS_START = 10'd656;
    localparam logic [9:0] HS_END   = 10'd751;
    localparam logic [9:0] VS_START = 10'd490;
    localparam logic [9:0] VS_END   = 10'd491;
    localparam logic [9:0] L_CW_M1  = 10'(CELL_W - 1);
    localparam logic [9:0] L_CH_M1  = 10'(CELL_H - 1);
    localparam logic [9:0] L_COLS   = 10'(GRID_COLS);
    localparam logic [9:0] L_ROWS   = 10'(GRID_ROWS);
    localparam logic [3:0] L_ROWS_M1 = 4'(GRID_ROWS - 1);

    logic [9:0] r_cnt_x, r_cnt_y;
    logic [9:0] r_sub_x, r_sub_y;
    logic [9:0] r_col, r_row;
    logic       r_frame_start;

    logic [9:0] r_s1_x, r_s1_y, r_s1_col, r_s1_row;
    logic       r_s1_de;
    logic [7:0] r_rgb;
    logic       r_hs, r_vs;

    logic [GRID_COLS-1:0] r_cells  [GRID_ROWS];
    logic [7:0]           r_colors [GRID_ROWS];
    logic                 r_wr_err;

    logic                 w_x_wrap, w_y_wrap;
    logic                 w_wr_acc, w_wr_in_range;
    logic [3:0]           w_srow;
    logic [GRID_COLS-1:0] w_row_bits;
    logic [7:0]           w_row_color;
    logic                 w_cell_bit;
    logic [7:0]           w_pix;

    assign w_x_wrap      = (r_cnt_x == H_LAST);
    assign w_y_wrap      = (r_cnt_y == V_LAST);
    assign wr_ready      = reset_n & (r_cnt_y >= V_VIS);
    assign w_wr_acc      = wr_valid & wr_ready;
    assign w_wr_in_range = ({6'd0, wr_row} < L_ROWS);

    // Sub-cell counters track CounterX/CELL_W and CounterY/CELL_H without a divider.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt_x       <= '0;
            r_cnt_y       <= '0;
            r_sub_x       <= '0;
            r_sub_y       <= '0;
            r_col         <= '0;
            r_row         <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= pix_ce & w_x_wrap & w_y_wrap;
            if (pix_ce) begin
                if (w_x_wrap) begin
                    r_cnt_x <= '0;
                    r_sub_x <= '0;
                    r_col   <= '0;
                    if (w_y_wrap) begin
                        r_cnt_y <= '0;
                        r_sub_y <= '0;
                        r_row   <= '0;
                    end else begin
                        r_cnt_y <= r_cnt_y + 10'd1;
                        if (r_sub_y == L_CH_M1) begin
                            r_sub_y <= '0;
                            r_row   <= r_row + 10'd1;
                        end else begin
                            r_sub_y <= r_sub_y + 10'd1;
                        end
                    end
                end else begin
                    r_cnt_x <= r_cnt_x + 10'd1;
                    if (r_sub_x == L_CW_M1) begin
                        r_sub_x <= '0;
                        r_col   <= r_col + 10'd1;
                    end else begin
                        r_sub_x <= r_sub_x + 10'd1;
                    end
                end
            end
        end
    end

    always_comb begin
        w_srow      = (FLIP_ROWS != 0) ? (L_ROWS_M1 - r_s1_row[3:0]) : r_s1_row[3:0];
        w_row_bits  = '0;
        w_row_color = '0;
        w_cell_bit  = 1'b0;
        for (int r = 0; r < GRID_ROWS; r++) begin
            if (w_srow == 4'(r)) begin
                w_row_bits  = r_cells[r];
                w_row_color = r_colors[r];
            end
        end
        for (int c = 0; c < GRID_COLS; c++) begin
            if (r_s1_col == 10'(c)) begin
                w_cell_bit = w_row_bits[c];
            end
        end
        if (!r_s1_de) begin
            w_pix = 8'h00;
        end else if ((r_s1_col >= L_COLS) || (r_s1_row >= L_ROWS)) begin
            w_pix = BG_COLOR;
        end else begin
            w_pix = w_cell_bit ? w_row_color : 8'h00;
        end
    end

    // Syncs are decoded from the stage-1 copy of the counters so they line up with RGB.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_x   <= '0;
            r_s1_y   <= '0;
            r_s1_col <= '0;
            r_s1_row <= '0;
            r_s1_de  <= 1'b0;
            r_rgb    <= '0;
            r_hs     <= 1'b1;
            r_vs     <= 1'b1;
        end else if (pix_ce) begin
            r_s1_x   <= r_cnt_x;
            r_s1_y   <= r_cnt_y;
            r_s1_col <= r_col;
            r_s1_row <= r_row;
            r_s1_de  <= (r_cnt_x < H_VIS) && (r_cnt_y < V_VIS);
            r_rgb    <= w_pix;
            r_hs     <= ~((r_s1_x >= HS_START) && (r_s1_x <= HS_END));
            r_vs     <= ~((r_s1_y >= VS_START) && (r_s1_y <= VS_END));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < GRID_ROWS; r++) begin
                r_cells[r]  <= '0;
                r_colors[r] <= '0;
            end
            r_wr_err <= 1'b0;
        end else begin
            r_wr_err <= 1'b0;
            if (clr) begin
                for (int r = 0; r < GRID_ROWS; r++) begin
                    r_cells[r] <= '0;
                end
            end else if (w_wr_acc) begin
                if (w_wr_in_range) begin
                    for (int r = 0; r < GRID_ROWS; r++) begin
                        if (wr_row == 4'(r)) begin
                            r_cells[r]  <= wr_data;
                            r_colors[r] <= wr_color;
                        end
                    end
                end else begin
                    r_wr_err <= 1'b1;
                end
            end
        end
    end

    assign wr_err      = r_wr_err;
    assign frame_start = r_frame_start;
    assign vga_h_sync  = r_hs;
    assign vga_v_sync  = r_vs;
    assign vga_r       = r_rgb[7:5];
    assign vga_g       = r_rgb[4:2];
    assign vga_b       = r_rgb[1:0];

endmodule

// File: tb/tb_vga_grid_renderer.sv
// Scoreboard bench for vga_grid_renderer: two configurations share one stimulus stream and are
// compared every clock against a coordinate-level reference model of the screen.
module tb_vga_grid_renderer;

    localparam int GR = 8;
    localparam int CH = 60;

    logic        clk = 1'b0;
    logic        reset_n, pix_ce, clr, wr_valid;
    logic [3:0]  wr_row;
    logic [15:0] wr_data;
    logic [7:0]  wr_color;

    logic       a_ready, a_err, a_hs, a_vs, a_fs;
    logic [2:0] a_r, a_g;
    logic [1:0] a_b;
    logic       b_ready, b_err, b_hs, b_vs, b_fs;
    logic [2:0] b_r, b_g;
    logic [1:0] b_b;

    vga_grid_renderer u_dut_a (
        .clk(clk), .reset_n(reset_n), .pix_ce(pix_ce), .clr(clr),
        .wr_valid(wr_valid), .wr_ready(a_ready), .wr_row(wr_row),
        .wr_data(wr_data[7:0]), .wr_color(wr_color), .wr_err(a_err),
        .vga_h_sync(a_hs), .vga_v_sync(a_vs),
        .vga_r(a_r), .vga_g(a_g), .vga_b(a_b), .frame_start(a_fs)
    );

    vga_grid_renderer #(.GRID_COLS(10), .CELL_W(40), .BG_COLOR(8'h03)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .pix_ce(pix_ce), .clr(clr),
        .wr_valid(wr_valid), .wr_ready(b_ready), .wr_row(wr_row),
        .wr_data(wr_data[9:0]), .wr_color(wr_color), .wr_err(b_err),
        .vga_h_sync(b_hs), .vga_v_sync(b_vs),
        .vga_r(b_r), .vga_g(b_g), .vga_b(b_b), .frame_start(b_fs)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       fs;
        logic       rdy;
        logic       err;
        logic [7:0] rgb_a;
        logic [7:0] rgb_b;
    } exp_t;

    int         cols [2] = '{8, 10};
    int         cw   [2] = '{80, 40};
    logic [7:0] bg   [2] = '{8'h00, 8'h03};
    logic [15:0] m_cells  [2][16];
    logic [7:0]  m_colors [2][16];
    int   mx, my, s1x, s1y;
    bit   s1de;
    exp_t exp_q [$];
    int   n_checks = 0;
    int   n_pass = 0;

    // Screen-space view: which cell a pixel lands in, with stored row r shown at GRID_ROWS-1-r.
    function automatic logic [7:0] ref_pixel(input int i, input int x, input int y);
        int col, row, sr;
        col = x / cw[i];
        row = y / CH;
        if (col >= cols[i] || row >= GR) return bg[i];
        sr = GR - 1 - row;
        return m_cells[i][sr][col] ? m_colors[i][sr] : 8'h00;
    endfunction

    task automatic check(input string nm, input logic [12:0] act, input logic [12:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s t=%0t model_xy=%0d,%0d: got {hs,vs,fs,rdy,err,rgb}=%h want %h",
                      nm, $time, mx, my, act, exp);
    endtask

    task automatic check_bound(input string nm, input int cyc, input int lim);
        n_checks++;
        if (cyc < lim) n_pass++;
        else $display("FAIL %s: waited %0d cycles, limit %0d", nm, cyc, lim);
    endtask

    initial begin
        exp_t e;
        logic ready_pre;
        e = '0;
        forever begin
            @(posedge clk);
            if (!reset_n) begin
                mx = 0; my = 0; s1x = 0; s1y = 0; s1de = 0;
                for (int i = 0; i < 2; i++)
                    for (int r = 0; r < 16; r++) begin
                        m_cells[i][r]  = '0;
                        m_colors[i][r] = '0;
                    end
                e = '0;
                e.hs = 1'b1;
                e.vs = 1'b1;
            end else begin
                ready_pre = (my >= 480);
                e.fs  = 1'b0;
                e.err = 1'b0;
                if (pix_ce) begin
                    e.rgb_a = s1de ? ref_pixel(0, s1x, s1y) : 8'h00;
                    e.rgb_b = s1de ? ref_pixel(1, s1x, s1y) : 8'h00;
                    e.hs = !(s1x >= 656 && s1x <= 751);
                    e.vs = !(s1y >= 490 && s1y <= 491);
                    s1x  = mx;
                    s1y  = my;
                    s1de = (mx < 640) && (my < 480);
                    e.fs = (mx == 799) && (my == 524);
                    mx++;
                    if (mx == 800) begin
                        mx = 0;
                        my++;
                        if (my == 525) my = 0;
                    end
                end
                if (clr) begin
                    for (int i = 0; i < 2; i++)
                        for (int r = 0; r < 16; r++) m_cells[i][r] = '0;
                end else if (wr_valid && ready_pre) begin
                    if (int'(wr_row) < GR) begin
                        for (int i = 0; i < 2; i++) begin
                            m_cells[i][wr_row]  = wr_data;
                            m_colors[i][wr_row] = wr_color;
                        end
                    end else begin
                        e.err = 1'b1;
                    end
                end
                e.rdy = (my >= 480);
            end
            exp_q.push_back(e);
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL scoreboard t=%0t: got no expected entry, want one per clock", $time);
            end else begin
                e = exp_q.pop_front();
                check("dut_a", {a_hs, a_vs, a_fs, a_ready, a_err, a_r, a_g, a_b},
                      {e.hs, e.vs, e.fs, e.rdy, e.err, e.rgb_a});
                check("dut_b", {b_hs, b_vs, b_fs, b_ready, b_err, b_r, b_g, b_b},
                      {e.hs, e.vs, e.fs, e.rdy, e.err, e.rgb_b});
            end
            if (n_checks - n_pass >= 30) begin
                $display("%0d/%0d checks passed", n_pass, n_checks);
                $finish;
            end
        end
    end

    task automatic wr(input logic [3:0] row, input logic [15:0] d, input logic [7:0] c,
                      input logic cl);
        @(negedge clk);
        wr_valid = 1'b1;
        wr_row   = row;
        wr_data  = d;
        wr_color = c;
        clr      = cl;
        @(negedge clk);
        wr_valid = 1'b0;
        clr      = 1'b0;
    endtask

    initial begin
        int cyc;
        reset_n = 1'b0; pix_ce = 1'b0; clr = 1'b0; wr_valid = 1'b0;
        wr_row = '0; wr_data = '0; wr_color = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Gated pixel clock with write/clear noise during visible scan.
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            pix_ce   = 1'($urandom_range(0, 1));
            wr_valid = 1'($urandom_range(0, 1));
            wr_row   = 4'($urandom);
            wr_data  = 16'($urandom);
            wr_color = 8'($urandom);
            clr      = ($urandom_range(0, 15) == 0);
        end

        // Write held across the visible area is taken once blanking opens.
        @(negedge clk);
        pix_ce = 1'b1; clr = 1'b0;
        wr_valid = 1'b1; wr_row = 4'd6; wr_data = 16'($urandom); wr_color = 8'h1C;
        cyc = 0;
        while (!a_ready && cyc < 500000) begin
            @(negedge clk);
            cyc++;
        end
        check_bound("wait_blanking", cyc, 500000);
        @(negedge clk);
        wr_valid = 1'b0;

        for (int r = 0; r < GR; r++) wr(4'(r), 16'($urandom), 8'($urandom), 1'b0);
        wr(4'd9, 16'hFFFF, 8'hFF, 1'b0);
        wr(4'd12, 16'hFFFF, 8'hFF, 1'b0);
        wr(4'd3, 16'hFFFF, 8'hFF, 1'b1);
        wr(4'd9, 16'hFFFF, 8'hFF, 1'b1);
        wr(4'd2, 16'($urandom), 8'($urandom), 1'b0);
        wr(4'd4, 16'($urandom), 8'($urandom), 1'b0);
        wr(4'd5, 16'($urandom), 8'($urandom), 1'b0);
        wr(4'd7, 16'($urandom), 8'($urandom), 1'b0);
        wr(4'd0, 16'h0001, 8'hE0, 1'b0);
        wr(4'd9, 16'hFFFF, 8'hFF, 1'b0);

        cyc = 0;
        while (!a_fs && cyc < 100000) begin
            @(negedge clk);
            cyc++;
        end
        check_bound("wait_frame_start", cyc, 100000);
        repeat (481 * 800) @(negedge clk);

        cyc = 0;
        while (!a_fs && cyc < 100000) begin
            @(negedge clk);
            cyc++;
        end
        check_bound("wait_frame_start_2", cyc, 100000);
        repeat (4000) @(negedge clk);

        // Reset pulse mid-frame with a write pending across it.
        reset_n = 1'b0;
        wr_valid = 1'b1; wr_row = 4'd2; wr_data = 16'hFFFF; wr_color = 8'hFF;
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        repeat (2000) @(negedge clk);
        wr_valid = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            pix_ce = 1'($urandom_range(0, 1));
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
